// File: rtl/noc_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_arb_pkg
// Description : Shared constants for the NoC output-stage arbiter: flit type
//               codes, default field widths and router port indices.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_arb_pkg;

  // Default geometry of the arbiter
  localparam int DEF_NUM_PORTS = 5;
  localparam int DEF_LEN_W     = 12;
  localparam int DEF_FLIT_ID_W = 3;

  // Flit type codes carried on flit_id
  localparam logic [DEF_FLIT_ID_W-1:0] HEADER_ID = 3'b001;
  localparam logic [DEF_FLIT_ID_W-1:0] BODY_ID   = 3'b010;
  localparam logic [DEF_FLIT_ID_W-1:0] TAIL_ID   = 3'b011;

  // Router port indices (Local, North, East, West, South)
  localparam int PORT_L = 0;
  localparam int PORT_N = 1;
  localparam int PORT_E = 2;
  localparam int PORT_W = 3;
  localparam int PORT_S = 4;

endpackage
`default_nettype wire

// File: rtl/noc_rr_timeout_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : noc_rr_timeout_arbiter_if
// Description : Request/grant bundle between the router input ports and the
//               output-stage arbiter.
//   req         : per-port request
//   flit_id     : per-port flit type, port p at [p*FLIT_ID_W +: FLIT_ID_W]
//   length      : per-port packet length, port p at [p*LEN_W +: LEN_W]
//   grant       : registered one-hot grant (all-zero = idle)
//   grant_valid : OR of grant
//   grant_idx   : index of the granted port (0 when idle)
//   timeout_evt : one-cycle pulse when a still-requesting port times out
//   master = input-port side, slave = arbiter side
// Revision    : 1.0 - initial release
// ============================================================================
interface noc_rr_timeout_arbiter_if
  import noc_arb_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int LEN_W     = DEF_LEN_W,
  parameter int FLIT_ID_W = DEF_FLIT_ID_W
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0]           req;
  logic [NUM_PORTS*FLIT_ID_W-1:0] flit_id;
  logic [NUM_PORTS*LEN_W-1:0]     length;
  logic [NUM_PORTS-1:0]           grant;
  logic                           grant_valid;
  logic [IDX_W-1:0]               grant_idx;
  logic [NUM_PORTS-1:0]           timeout_evt;

  modport master (
    output req, flit_id, length,
    input  grant, grant_valid, grant_idx, timeout_evt
  );

  modport slave (
    input  req, flit_id, length,
    output grant, grant_valid, grant_idx, timeout_evt
  );

endinterface
`default_nettype wire

// File: rtl/noc_port_timer.sv
`default_nettype none
// ============================================================================
// Module      : noc_port_timer
// Description : Per-port packet timer. Latches the packet length from every
//               header flit and counts cycles while the port keeps its grant.
//   clk, rst : clock, synchronous active-high reset
//   flit_id  : flit type of this port
//   length   : packet length of this port
//   run      : port is granted and kept this cycle (count advances)
//   timesup  : count >= limit
// Revision    : 1.0 - initial release
// ============================================================================
module noc_port_timer
  import noc_arb_pkg::*;
#(
  parameter int                   LEN_W     = DEF_LEN_W,
  parameter int                   FLIT_ID_W = DEF_FLIT_ID_W,
  parameter logic [FLIT_ID_W-1:0] HDR_ID    = HEADER_ID
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic [FLIT_ID_W-1:0] flit_id,
  input  wire logic [LEN_W-1:0]     length,
  input  wire logic                 run,
  output logic                      timesup
);

  logic [LEN_W-1:0] r_limit;
  logic [LEN_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_limit <= '0;
      r_count <= '0;
    end else begin
      // A header updates the limit even mid-grant; the compare in this cycle
      // still sees the old value.
      if (flit_id == HDR_ID) begin
        r_limit <= length;
      end
      // Any cycle in which the port is not kept restarts the count, so a new
      // grantee always begins at zero. Saturate instead of wrapping.
      if (run) begin
        r_count <= (&r_count) ? r_count : r_count + LEN_W'(1);
      end else begin
        r_count <= '0;
      end
    end
  end

  // >= rather than == so a limit shrunk below the running count still fires
  assign timesup = (r_count >= r_limit);

endmodule
`default_nettype wire

// File: rtl/noc_rr_timeout_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : noc_rr_timeout_arbiter
// Description : N-port round-robin arbiter with per-port packet timeout for
//               the NoC router output stage. A grant is held while its port
//               keeps requesting and its timer has not expired.
//   clk, rst : clock, synchronous active-high reset
//   bus      : request/grant bundle (slave side), see the interface file
// Revision    : 1.0 - initial release
// ============================================================================
module noc_rr_timeout_arbiter #(
  parameter int                   NUM_PORTS = noc_arb_pkg::DEF_NUM_PORTS,
  parameter int                   LEN_W     = noc_arb_pkg::DEF_LEN_W,
  parameter int                   FLIT_ID_W = noc_arb_pkg::DEF_FLIT_ID_W,
  parameter logic [FLIT_ID_W-1:0] HEADER_ID = noc_arb_pkg::HEADER_ID
) (
  input  wire logic                clk,
  input  wire logic                rst,
  noc_rr_timeout_arbiter_if.slave  bus
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0] r_grant;
  logic [IDX_W-1:0]     r_grant_idx;
  logic [IDX_W-1:0]     r_rr_ptr;
  logic [NUM_PORTS-1:0] r_timeout_evt;

  logic [NUM_PORTS-1:0] w_timesup;
  logic [NUM_PORTS-1:0] w_run;
  logic                 w_keep;
  logic [NUM_PORTS-1:0] w_scan;
  logic [NUM_PORTS-1:0] w_grant_nxt;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic [IDX_W-1:0]     w_ptr_nxt;
  logic [NUM_PORTS-1:0] w_evt_nxt;
  logic                 w_found;
  logic [IDX_W-1:0]     w_pos;
  int                   w_sum;

  generate
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      noc_port_timer #(
        .LEN_W     (LEN_W),
        .FLIT_ID_W (FLIT_ID_W),
        .HDR_ID    (HEADER_ID)
      ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .flit_id (bus.flit_id[p*FLIT_ID_W +: FLIT_ID_W]),
        .length  (bus.length[p*LEN_W +: LEN_W]),
        .run     (w_run[p]),
        .timesup (w_timesup[p])
      );
    end
  endgenerate

  // Masking with the grant keeps an unrequested port's (possibly unknown)
  // timer state out of every decision.
  assign w_run  = r_grant & bus.req & ~w_timesup;
  assign w_keep = |w_run;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant       <= '0;
      r_grant_idx   <= '0;
      r_rr_ptr      <= '0;
      r_timeout_evt <= '0;
    end else begin
      r_grant       <= w_grant_nxt;
      r_grant_idx   <= w_idx_nxt;
      r_rr_ptr      <= w_ptr_nxt;
      r_timeout_evt <= w_evt_nxt;
    end
  end

  // Next-grant decision. While busy, rr_ptr already equals g+1, so a release
  // scan starting at rr_ptr with g masked out visits g+1 .. g-1; when idle
  // the mask is empty and the scan starts at rr_ptr as well.
  always_comb begin
    w_grant_nxt = r_grant;
    w_idx_nxt   = r_grant_idx;
    w_ptr_nxt   = r_rr_ptr;
    w_scan      = bus.req & ~r_grant;
    w_found     = 1'b0;
    w_sum       = 0;
    w_pos       = '0;
    if (!w_keep) begin
      w_grant_nxt = '0;
      w_idx_nxt   = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        w_sum = int'(r_rr_ptr) + i;
        if (w_sum >= NUM_PORTS) begin
          w_sum = w_sum - NUM_PORTS;
        end
        w_pos = IDX_W'(w_sum);
        if (!w_found && w_scan[w_pos]) begin
          w_found     = 1'b1;
          w_grant_nxt = NUM_PORTS'(1) << w_pos;
          w_idx_nxt   = w_pos;
          w_ptr_nxt   = (w_sum == NUM_PORTS - 1) ? '0 : w_pos + IDX_W'(1);
        end
      end
    end
    // Only a release caused by the timer while the port still requests
    w_evt_nxt = r_grant & bus.req & w_timesup;
  end

  // Outputs straight from the registers
  always_comb begin
    bus.grant       = r_grant;
    bus.grant_valid = |r_grant;
    bus.grant_idx   = r_grant_idx;
    bus.timeout_evt = r_timeout_evt;
  end

endmodule
`default_nettype wire

// File: tb/tb_noc_rr_timeout_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_rr_timeout_arbiter
// Description : Directed self-checking bench for noc_rr_timeout_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_rr_timeout_arbiter;

  localparam int NP = 5;
  localparam int LW = 12;
  localparam int FW = 3;
  localparam logic [FW-1:0] HDR  = 3'b001;
  localparam logic [FW-1:0] BODY = 3'b010;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  noc_rr_timeout_arbiter_if #(.NUM_PORTS(NP), .LEN_W(LW), .FLIT_ID_W(FW)) bus ();

  noc_rr_timeout_arbiter #(
    .NUM_PORTS (NP),
    .LEN_W     (LW),
    .FLIT_ID_W (FW),
    .HEADER_ID (HDR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the active edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_flit(input int p, input logic [FW-1:0] id, input logic [LW-1:0] len);
    bus.flit_id[p*FW +: FW] = id;
    bus.length[p*LW +: LW]  = len;
  endtask

  task automatic all_body;
    for (int p = 0; p < NP; p++) set_flit(p, BODY, 12'd0);
  endtask

  task automatic test_reset;
    bus.req = '0;
    all_body();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.grant !== 5'b0 || bus.grant_valid !== 1'b0 || bus.grant_idx !== 3'd0 || bus.timeout_evt !== 5'b0) begin
      errors++;
      $display("FAIL reset_state: grant=%b valid=%b idx=%0d evt=%b required all zero",
               bus.grant, bus.grant_valid, bus.grant_idx, bus.timeout_evt);
    end
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (bus.grant !== 5'b0 || bus.grant_valid !== 1'b0 || bus.grant_idx !== 3'd0 || bus.timeout_evt !== 5'b0) begin
        errors++;
        $display("FAIL idle_cycle%0d: grant=%b valid=%b idx=%0d evt=%b required all zero",
                 c, bus.grant, bus.grant_valid, bus.grant_idx, bus.timeout_evt);
      end
    end
  endtask

  // Port 1, limit 3: four grant cycles, timeout pulse with one idle cycle,
  // then re-grant.
  task automatic test_hold_timeout;
    logic [NP-1:0] exp_g [6];
    logic [NP-1:0] exp_e [6];
    exp_g = '{5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b00000, 5'b00010};
    exp_e = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00010, 5'b00000};
    set_flit(1, HDR, 12'd3);
    bus.req = 5'b00010;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c == 0) set_flit(1, BODY, 12'd0);
      checks++;
      if (bus.grant !== exp_g[c] || bus.timeout_evt !== exp_e[c] || bus.grant_valid !== (|exp_g[c])) begin
        errors++;
        $display("FAIL hold_timeout_c%0d: grant=%b evt=%b valid=%b required grant=%b evt=%b",
                 c, bus.grant, bus.timeout_evt, bus.grant_valid, exp_g[c], exp_e[c]);
      end
      if (exp_g[c] != 5'b0) begin
        checks++;
        if (bus.grant_idx !== 3'd1) begin
          errors++;
          $display("FAIL hold_timeout_idx_c%0d: idx=%0d required 1", c, bus.grant_idx);
        end
      end
    end
    bus.req = '0;
    tick();
    checks++;
    if (bus.grant !== 5'b0 || bus.timeout_evt !== 5'b0) begin
      errors++;
      $display("FAIL hold_timeout_release: grant=%b evt=%b required 00000/00000", bus.grant, bus.timeout_evt);
    end
  endtask

  // Fresh reset, all ports with limit 0: one-cycle grants rotating 0..4,0,
  // each release being a timeout of the previous grantee.
  task automatic test_rotation;
    logic [NP-1:0] eg;
    logic [NP-1:0] ee;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req = 5'b11111;
    for (int c = 0; c < 6; c++) begin
      tick();
      eg = 5'b00001 << (c % NP);
      ee = (c == 0) ? 5'b00000 : (5'b00001 << ((c - 1) % NP));
      checks++;
      if (bus.grant !== eg || bus.grant_idx !== 3'(c % NP) || bus.timeout_evt !== ee) begin
        errors++;
        $display("FAIL rotation_c%0d: grant=%b idx=%0d evt=%b required grant=%b idx=%0d evt=%b",
                 c, bus.grant, bus.grant_idx, bus.timeout_evt, eg, c % NP, ee);
      end
    end
    bus.req = '0;
    tick();
    checks++;
    if (bus.grant !== 5'b0 || bus.timeout_evt !== 5'b0) begin
      errors++;
      $display("FAIL rotation_end: grant=%b evt=%b required 00000/00000", bus.grant, bus.timeout_evt);
    end
  endtask

  // Port 2 (limit 10) drops req after two cycles; port 4 takes over with no
  // timeout pulse. Unrequested ports carry unknown flit fields.
  task automatic test_req_drop;
    set_flit(0, 'x, 'x);
    set_flit(1, 'x, 'x);
    set_flit(3, 'x, 'x);
    set_flit(2, HDR, 12'd10);
    bus.req = 5'b00100;
    tick();
    checks++;
    if (bus.grant !== 5'b00100 || bus.grant_idx !== 3'd2) begin
      errors++;
      $display("FAIL req_drop_c1: grant=%b idx=%0d required 00100 idx 2", bus.grant, bus.grant_idx);
    end
    set_flit(2, BODY, 12'd0);
    bus.req = 5'b10100;
    tick();
    checks++;
    if (bus.grant !== 5'b00100) begin
      errors++;
      $display("FAIL req_drop_c2: grant=%b required 00100", bus.grant);
    end
    bus.req = 5'b10000;
    tick();
    checks++;
    if (bus.grant !== 5'b10000 || bus.grant_idx !== 3'd4 || bus.timeout_evt !== 5'b0) begin
      errors++;
      $display("FAIL req_drop_c3: grant=%b idx=%0d evt=%b required 10000 idx 4 evt 00000",
               bus.grant, bus.grant_idx, bus.timeout_evt);
    end
    bus.req = '0;
    tick();
    checks++;
    if (bus.grant !== 5'b0 || bus.timeout_evt !== 5'b0) begin
      errors++;
      $display("FAIL req_drop_c4: grant=%b evt=%b required 00000/00000", bus.grant, bus.timeout_evt);
    end
    all_body();
  endtask

  // Port 0 limit 8; header with length 2 arrives at count 5. Old limit is
  // used that cycle, count 6 >= 2 next cycle -> release with timeout.
  task automatic test_header_shrink;
    set_flit(0, HDR, 12'd8);
    bus.req = 5'b00001;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) set_flit(0, BODY, 12'd0);
      checks++;
      if (bus.grant !== 5'b00001 || bus.grant_idx !== 3'd0 || bus.timeout_evt !== 5'b0) begin
        errors++;
        $display("FAIL shrink_c%0d: grant=%b idx=%0d evt=%b required 00001 idx 0 evt 00000",
                 c, bus.grant, bus.grant_idx, bus.timeout_evt);
      end
      if (c == 6) set_flit(0, HDR, 12'd2);
      if (c == 7) set_flit(0, BODY, 12'd0);
    end
    tick();
    checks++;
    if (bus.grant !== 5'b0 || bus.timeout_evt !== 5'b00001) begin
      errors++;
      $display("FAIL shrink_release: grant=%b evt=%b required 00000/00001", bus.grant, bus.timeout_evt);
    end
    bus.req = '0;
    tick();
    checks++;
    if (bus.grant !== 5'b0 || bus.timeout_evt !== 5'b0) begin
      errors++;
      $display("FAIL shrink_after: grant=%b evt=%b required 00000/00000", bus.grant, bus.timeout_evt);
    end
  endtask

  // Reset while port 3 is mid-packet: grant clears, rr_ptr returns to 0 so
  // port 0 wins over port 3 afterwards.
  task automatic test_reset_mid_grant;
    set_flit(3, HDR, 12'd20);
    bus.req = 5'b01000;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 1) set_flit(3, BODY, 12'd0);
      checks++;
      if (bus.grant !== 5'b01000 || bus.grant_idx !== 3'd3) begin
        errors++;
        $display("FAIL midrst_pre_c%0d: grant=%b idx=%0d required 01000 idx 3", c, bus.grant, bus.grant_idx);
      end
    end
    rst = 1'b1;
    bus.req = 5'b01001;
    tick();
    checks++;
    if (bus.grant !== 5'b0 || bus.grant_valid !== 1'b0 || bus.timeout_evt !== 5'b0 || bus.grant_idx !== 3'd0) begin
      errors++;
      $display("FAIL midrst_reset: grant=%b valid=%b idx=%0d evt=%b required all zero",
               bus.grant, bus.grant_valid, bus.grant_idx, bus.timeout_evt);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.grant !== 5'b00001 || bus.grant_idx !== 3'd0 || bus.timeout_evt !== 5'b0) begin
      errors++;
      $display("FAIL midrst_first: grant=%b idx=%0d evt=%b required 00001 idx 0 evt 00000",
               bus.grant, bus.grant_idx, bus.timeout_evt);
    end
    // Limits were cleared, so port 0 times out after one cycle
    tick();
    checks++;
    if (bus.grant !== 5'b01000 || bus.grant_idx !== 3'd3 || bus.timeout_evt !== 5'b00001) begin
      errors++;
      $display("FAIL midrst_second: grant=%b idx=%0d evt=%b required 01000 idx 3 evt 00001",
               bus.grant, bus.grant_idx, bus.timeout_evt);
    end
    bus.req = '0;
    tick();
    checks++;
    if (bus.grant !== 5'b0 || bus.timeout_evt !== 5'b0) begin
      errors++;
      $display("FAIL midrst_end: grant=%b evt=%b required 00000/00000", bus.grant, bus.timeout_evt);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    bus.req = '0;
    all_body();
    test_reset();
    test_hold_timeout();
    test_rotation();
    test_req_drop();
    test_header_shrink();
    test_reset_mid_grant();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/noc_rr_timeout_arbiter.md
Name: noc_rr_timeout_arbiter

Overview:
- Parametrised N-port round-robin arbiter for the NoC router output stage.
- Grants one input port at a time. The grant is held while the port keeps requesting and its per-port packet timer has not expired.
- Successor of the fixed 5-port L/N/E/W/S fixed-order arbiter. Adds:
  - generic port count and widths
  - true rotating priority
  - registered one-hot and encoded grant outputs
  - timeout event reporting
  - robust `>=` timeout compare

Parameters:
- NUM_PORTS, 5, number of requesting input ports; index 0 = Local.
- LEN_W, 12, width of the packet length / timeout value in clock cycles.
- FLIT_ID_W, 3, width of the flit type field.
- HEADER_ID, 3'b001, flit_id value that marks a header flit and latches its length.
- IDX_W, $clog2(NUM_PORTS), width of the encoded grant index (derived; not overridden).

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous, active-high reset.
- req, in, NUM_PORTS, per-port request.
- flit_id, in, NUM_PORTS*FLIT_ID_W, per-port flit type; port p occupies bits [p*FLIT_ID_W +: FLIT_ID_W].
- length, in, NUM_PORTS*LEN_W, per-port packet length; same packing as flit_id.
- grant, out, NUM_PORTS, registered one-hot grant; all-zero means idle.
- grant_valid, out, 1, OR of grant.
- grant_idx, out, IDX_W, index of the granted port; 0 when idle.
- timeout_evt, out, NUM_PORTS, one-cycle pulse when port p loses its grant due to timeout while req[p]=1.

Behaviour:
- Reset:
  - grant=0, grant_valid=0, grant_idx=0, timeout_evt=0.
  - All limits=0, all counts=0.
  - rr_ptr=0 (port 0 has highest priority first).
- limit[p]: loaded with length[p] on any clock where flit_id[p]==HEADER_ID. This is independent of grant; a new header mid-grant updates the limit.
- timesup[p] = (count[p] >= limit[p]), combinational.
- keep = grant_valid && req[g] && !timesup[g], where g = grant_idx.
- Next-grant decision (combinational, registered on clk):
  - IDLE (grant=0): grant the first p with req[p]=1, scanning rr_ptr, rr_ptr+1, … mod NUM_PORTS. If none, stay idle.
  - BUSY, keep=1: grant unchanged; count[g] increments.
  - BUSY, keep=0: scan g+1 … g+NUM_PORTS-1 mod NUM_PORTS, excluding g. If no other request, go idle for at least one cycle; g may be re-granted on the following cycle.
- rr_ptr is updated to (new grantee + 1) mod NUM_PORTS whenever a new grant is issued.
- count[p] is cleared on every cycle where port p is not kept, i.e. not granted or about to be released. A new grantee therefore starts at 0.
- Latency:
  - req to grant = 1 cycle from idle.
  - A grant with limit L and req held lasts exactly L+1 cycles.
  - L=0 gives a 1-cycle grant.
- timeout_evt[g] pulses in the cycle grant[g] falls, only if req[g]=1 and timesup[g]=1 in the deciding cycle. A release because req dropped produces no pulse.
- Simultaneous header and timeout: timesup uses the old limit in that cycle; the new limit applies next cycle.
- Count width is LEN_W and saturates at all-ones (never wraps).
- Reset mid-grant: grant drops to 0 on the next edge and all state clears. No timeout_evt is generated.
- If the flit_id/length inputs carry X on unrequested ports, the grant must be unaffected.

Decomposition:
- Shared package noc_arb_pkg:
  - flit-type constants (HEADER_ID, BODY_ID, TAIL_ID)
  - default LEN_W / FLIT_ID_W
  - port-index constants (PORT_L=0, N=1, E=2, W=3, S=4)
- Sub-module noc_port_timer, one instance per port:
  - Owns the limit register, count register and timesup compare.
  - Inputs: clk, rst, flit_id, length, run.
  - Output: timesup.
- Top level holds the round-robin scan, rr_ptr, the grant register and the event logic.

Test Plan:
1. Reset, then req=0 for 5 cycles -> grant=0, grant_valid=0, timeout_evt=0 throughout.
2. Port 1 sends a header with length=3, then holds req[1]=1 -> grant=5'b00010 for exactly 4 cycles. timeout_evt[1] pulses as the grant falls; idle 1 cycle; re-granted.
3. All 5 ports request with length=0 -> grants rotate 0,1,2,3,4,0, one cycle each; grant_idx matches.
4. Port 2 granted with length=10; req[2] drops after 2 cycles while req[4]=1 -> grant moves to port 4 the next cycle; no timeout_evt.
5. Port 0 granted with length=8; at count=5 a new header carries length=2 -> timesup is asserted next cycle, the grant is released, and timeout_evt[0]=1 (no wrap).
6. rst asserted while port 3 is granted mid-packet -> grant=0 and rr_ptr=0 after the next edge. The following requests from ports 3 and 0 grant port 0 first.
